// File: rtl/serial_adder_driver_if.sv
// Handshake and serial-link bundle between the operand source, the
// serial_adder_driver, the external serial adder and the sum consumer.
interface serial_adder_driver_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_a;
  logic             ser_b;
  logic             ser_s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;

  // master: the driver block itself
  modport master (
    input  in_valid, in_a, in_b, ser_s, out_ready,
    output in_ready, ser_valid, ser_first, ser_a, ser_b, out_valid, out_sum
  );

  // slave: the environment (operand source, serial adder, consumer)
  modport slave (
    output in_valid, in_a, in_b, ser_s, out_ready,
    input  in_ready, ser_valid, ser_first, ser_a, ser_b, out_valid, out_sum
  );
endinterface

// File: rtl/serial_adder_driver.sv
// Parallel-to-serial operand driver for an external bit-serial adder:
// streams A/B LSB first plus one carry-flush bit, then reassembles the sum.
module serial_adder_driver #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_adder_driver_if.master bus
);

  localparam int unsigned    CW   = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum_q;
  logic [WIDTH:0]   sum_d;
  logic             shifting;

  // Sum bits enter at the MSB; after WIDTH+1 shifts bit i sits at index i.
  assign sum_d    = {bus.ser_s, sum_q[WIDTH:1]};
  assign shifting = (state_q == SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            cnt_q   <= '0;
            sum_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // Zero fill makes the final flush cycle present 0/0 naturally.
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          sum_q <= sum_d;
          if (cnt_q == LAST) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.ser_valid = shifting;
  assign bus.ser_first = shifting && (cnt_q == '0);
  assign bus.ser_a     = shifting & a_q[0];
  assign bus.ser_b     = shifting & b_q[0];
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;

endmodule

// File: tb/tb_serial_adder_driver.sv
// Bench for serial_adder_driver with a behavioural serial adder in the loop;
// expected sums come from plain integer addition of the operands.
module tb_serial_adder_driver;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic carry_q = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  serial_adder_driver_if #(.WIDTH(W)) bus ();

  serial_adder_driver #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Serial adder: S = a ^ b ^ c, carry registered, cleared by ser_first.
  logic cin;
  assign cin        = bus.ser_first ? 1'b0 : carry_q;
  assign bus.ser_s  = bus.ser_a ^ bus.ser_b ^ cin;
  always_ff @(posedge clk) begin
    if (bus.ser_valid)
      carry_q <= (bus.ser_a & bus.ser_b) | (bus.ser_a & cin) | (bus.ser_b & cin);
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   sum;
    int           stall;
    bit           junk;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  1);
    check({tag, "_ser_valid"}, 32'(bus.ser_valid), 0);
    check({tag, "_ser_first"}, 32'(bus.ser_first), 0);
    check({tag, "_ser_a"},     32'(bus.ser_a),     0);
    check({tag, "_ser_b"},     32'(bus.ser_b),     0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_sum"},   32'(bus.out_sum),   0);
  endtask

  // One complete frame; junk=1 keeps in_valid high with other operands
  // while the block is busy, stall = DONE cycles held with out_ready=0.
  task automatic do_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W:0] exp, input int stall, input bit junk);
    logic [W:0] sa, sb, sf, got;
    int nv, lat;
    sa = '0; sb = '0; sf = '0; nv = 0; lat = -1; got = '0;
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 1);
    bus.out_ready = (stall == 0);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.in_valid = junk;
        bus.in_a     = ~a;
        bus.in_b     = b ^ 4'h5;
      end
      if (c > 1) check("in_ready_busy", 32'(bus.in_ready), 0);
      if (bus.ser_valid) begin
        if (nv <= int'(W)) begin
          sa[nv] = bus.ser_a;
          sb[nv] = bus.ser_b;
          sf[nv] = bus.ser_first;
        end
        nv++;
      end
      if (bus.out_valid) begin
        lat = c;
        got = bus.out_sum;
        break;
      end
    end
    check("latency",        32'(lat), W + 2);
    check("ser_valid_cnt",  32'(nv),  W + 1);
    check("ser_a_seq",      32'(sa),  32'({1'b0, a}));
    check("ser_b_seq",      32'(sb),  32'({1'b0, b}));
    check("ser_first_seq",  32'(sf),  1);
    check("ser_valid_done", 32'(bus.ser_valid), 0);
    check("out_sum",        32'(got), 32'(exp));
    for (int j = 0; j < stall; j++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(bus.out_valid), 1);
      check("stall_out_sum",   32'(bus.out_sum),   32'(exp));
      check("stall_in_ready",  32'(bus.in_ready),  0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("post_out_valid", 32'(bus.out_valid), 0);
    check("post_in_ready",  32'(bus.in_ready),  1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int nov;

    tbl[0] = '{a: 4'd5,  b: 4'd3,  sum: 5'd8,  stall: 0, junk: 1'b0};
    tbl[1] = '{a: 4'd15, b: 4'd15, sum: 5'd30, stall: 0, junk: 1'b0};
    tbl[2] = '{a: 4'd0,  b: 4'd0,  sum: 5'd0,  stall: 0, junk: 1'b0};
    tbl[3] = '{a: 4'd10, b: 4'd6,  sum: 5'd16, stall: 3, junk: 1'b0};
    tbl[4] = '{a: 4'd9,  b: 4'd12, sum: 5'd21, stall: 0, junk: 1'b1};
    tbl[5] = '{a: 4'd1,  b: 4'd15, sum: 5'd16, stall: 2, junk: 1'b1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      do_frame(tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].stall, tbl[i].junk);

    // Abort in SHIFT cycle 2; reset also beats a simultaneous in_valid.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = 4'd9; bus.in_b = 4'd6;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("shift_before_rst", 32'(bus.ser_valid), 1);
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 4'd3; bus.in_b = 4'd3;
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check_reset_outputs("midrst");
    nov = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid || bus.ser_valid) nov++;
    end
    check("midrst_no_activity", 32'(nov), 0);
    do_frame(4'd7, 4'd9, 5'd16, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      do_frame(ra, rb, (W+1)'(int'(ra) + int'(rb)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
